// File: rtl/uart_rx_buffer.sv
// Receive-side byte buffer for a UART: first-word-fall-through FIFO of {ferr, data}
// entries with fill level, threshold interrupt and a sticky overrun flag.
module uart_rx_buffer #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned THRESH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [7:0]               rx_data,
    input  logic                     rx_valid,
    input  logic                     rx_ferr,
    input  logic                     rd_ready,
    input  logic                     clr_ovr,
    output logic [7:0]               rd_data,
    output logic                     rd_ferr,
    output logic                     rd_valid,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     overrun,
    output logic                     irq_thresh
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned LVL_W = AW + 1;

    logic [8:0]       r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic             r_overrun;

    logic             w_push;
    logic             w_pop;
    logic             w_drop;
    logic [8:0]       w_head;

    // Flags are pure functions of the level counter.
    assign rd_valid   = (r_level != '0);
    assign full       = (r_level == LVL_W'(DEPTH));
    assign irq_thresh = (r_level >= LVL_W'(THRESH));
    assign level      = r_level;
    assign overrun    = r_overrun;

    // A pop frees the slot in the same cycle, so a full buffer still accepts.
    assign w_pop  = rd_valid && rd_ready;
    assign w_push = rx_valid && (!full || w_pop);
    assign w_drop = rx_valid && !w_push;

    assign w_head  = r_mem[r_rd_ptr];
    assign rd_data = rd_valid ? w_head[7:0] : 8'h00;
    assign rd_ferr = rd_valid ? w_head[8]   : 1'b0;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {rx_ferr, rx_data};
        end
    end

    // Pointer width equals log2(DEPTH), so increment wraps DEPTH-1 -> 0 naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // A new drop takes priority over a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overrun <= 1'b0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
        end else if (clr_ovr) begin
            r_overrun <= 1'b0;
        end
    end

endmodule
